// File: rtl/destsel_pkg.sv
// Shared types for the destination-select write path: register count, select width,
// queued write entry layout and the select-to-onehot helper. Byte enables exist only under DESTSEL_BYTE_EN.
package destsel_pkg;

  localparam int NUM_REGS = 4;
  localparam int SEL_W    = 2;
  localparam int DATA_W   = 16;
`ifdef DESTSEL_BYTE_EN
  localparam int BE_W     = DATA_W / 8;
`endif

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
`ifdef DESTSEL_BYTE_EN
    logic [BE_W-1:0]   be;
`endif
  } wr_entry_t;

  function automatic logic [NUM_REGS-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/destsel_if.sv
// Write-request handshake into destsel_writer: valid/ready plus destination select and data.
// wrBe is present only when DESTSEL_BYTE_EN is defined.
interface destsel_if
  import destsel_pkg::*;
#(
  parameter int nrOfBits = DATA_W
);

  logic                wrValid;
  logic                wrReady;
  logic [SEL_W-1:0]    wrSel;
  logic [nrOfBits-1:0] wrData;
`ifdef DESTSEL_BYTE_EN
  logic [nrOfBits/8-1:0] wrBe;

  modport master (output wrValid, output wrSel, output wrData, output wrBe, input wrReady);
  modport slave  (input wrValid, input wrSel, input wrData, input wrBe, output wrReady);
`else
  modport master (output wrValid, output wrSel, output wrData, input wrReady);
  modport slave  (input wrValid, input wrSel, input wrData, output wrReady);
`endif

endinterface

// File: rtl/destsel_fifo.sv
// DEPTH-entry circular buffer of wr_entry_t (DEPTH a power of two, >= 2); head is read combinationally.
// Caller must not push when full nor pop when empty; a per-slot valid/sel view feeds hazard tracking.
module destsel_fifo
  import destsel_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pushEn,
  input  wr_entry_t        pushEntry,
  input  logic             popEn,
  output wr_entry_t        headEntry,
  output logic [CNT_W-1:0] count,
  output logic [SEL_W-1:0] entrySel [DEPTH],
  output logic [DEPTH-1:0] entryValid
);

  wr_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] offs [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (pushEn) mem[wrPtr] <= pushEntry;
  end

  assign headEntry = mem[rdPtr];

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    entryValid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs[i]       = PTR_W'(i) - rdPtr;
      entryValid[i] = ({1'b0, offs[i]} < count);
      entrySel[i]   = mem[i].sel;
    end
  end

endmodule

// File: rtl/destsel_writer.sv
// Queues (sel,data) writes and commits the head into reg0..reg3 while drainEn; visible one edge after commit, >=1 edge after accept.
// wrReady drops when full (no pass-through); writes offered while not ready are dropped and latch overflowErr. Optional DESTSEL_BYTE_EN.
module destsel_writer
  import destsel_pkg::*;
#(
  parameter  int                  nrOfBits  = DATA_W,
  parameter  int                  DEPTH     = 2,
  parameter  logic [nrOfBits-1:0] RESET_VAL = '0,
  localparam int                  CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  destsel_if.slave            wr,
  input  logic                drainEn,
  output logic [nrOfBits-1:0] reg0,
  output logic [nrOfBits-1:0] reg1,
  output logic [nrOfBits-1:0] reg2,
  output logic [nrOfBits-1:0] reg3,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    count,
  output logic                overflowErr
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic                push;
  logic                pop;
  wr_entry_t           pushEntry;
  wr_entry_t           head;
  logic [SEL_W-1:0]    entrySel [DEPTH];
  logic [DEPTH-1:0]    entryValid;
  logic [nrOfBits-1:0] regFile [NUM_REGS];
  logic [nrOfBits-1:0] merged;

  // Ready depends on registered occupancy only, so a full FIFO stays closed even while draining.
  assign wr.wrReady = (count < DEPTH_C);
  assign push       = wr.wrValid & wr.wrReady;
  assign pop        = drainEn & (count != '0);

  always_comb begin
    pushEntry      = '0;
    pushEntry.sel  = wr.wrSel;
    pushEntry.data = DATA_W'(wr.wrData);
`ifdef DESTSEL_BYTE_EN
    pushEntry.be   = BE_W'(wr.wrBe);
`endif
  end

  destsel_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .pushEn     (push),
    .pushEntry  (pushEntry),
    .popEn      (pop),
    .headEntry  (head),
    .count      (count),
    .entrySel   (entrySel),
    .entryValid (entryValid)
  );

  // Byte-masked merge of the head entry over the current contents of its target register.
  always_comb begin
`ifdef DESTSEL_BYTE_EN
    merged = regFile[head.sel];
    for (int b = 0; b < nrOfBits / 8; b++) begin
      if (head.be[b]) merged[b*8 +: 8] = head.data[b*8 +: 8];
    end
`else
    merged = nrOfBits'(head.data);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= RESET_VAL;
    end else if (pop) begin
      regFile[head.sel] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflowErr <= 1'b0;
    end else if (wr.wrValid && !wr.wrReady) begin
      overflowErr <= 1'b1;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i]) pending = pending | onehot4(entrySel[i]);
    end
  end

  assign reg0 = regFile[0];
  assign reg1 = regFile[1];
  assign reg2 = regFile[2];
  assign reg3 = regFile[3];

endmodule

// File: tb/tb_destsel_writer.sv
// Randomised and directed bench for destsel_writer against a queue-based write model.
module tb_destsel_writer;

  localparam int W     = 16;
  localparam int DEPTH = 2;
`ifdef DESTSEL_BYTE_EN
  localparam bit BE_ON = 1'b1;
`else
  localparam bit BE_ON = 1'b0;
`endif

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         drainEn = 1'b0;
  logic [W-1:0] reg0, reg1, reg2, reg3;
  logic [3:0]   pending;
  logic [1:0]   count;
  logic         overflowErr;
  logic [1:0]   curBe;

  destsel_if #(.nrOfBits(W)) wrIf ();

  destsel_writer #(
    .nrOfBits  (W),
    .DEPTH     (DEPTH),
    .RESET_VAL (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wrIf.slave),
    .drainEn     (drainEn),
    .reg0        (reg0),
    .reg1        (reg1),
    .reg2        (reg2),
    .reg3        (reg3),
    .pending     (pending),
    .count       (count),
    .overflowErr (overflowErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    logic [1:0]  be;
  } ment_t;

  ment_t       mq[$];
  logic [15:0] mReg [4];
  logic        mOvf;
  int          tests = 0;
  int          fails = 0;
  bit          chkOn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    for (int i = 0; i < 4; i++) mReg[i] = 16'h0000;
    mOvf = 1'b0;
  endtask

  function automatic logic [3:0] expPending();
    logic [3:0] r;
    r = 4'b0000;
    foreach (mq[k]) r[mq[k].sel] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] regAt(input int i);
    case (i)
      0:       return reg0;
      1:       return reg1;
      2:       return reg2;
      default: return reg3;
    endcase
  endfunction

  // Model: an in-order queue of pending writes applied to four registers.
  always @(posedge clk) begin
    if (rst_n) begin
      ment_t e;
      ment_t h;
      bit    rdy;
      bit    doC;
      rdy = (mq.size() < DEPTH);
      doC = (mq.size() > 0) && drainEn;
      if (doC) h = mq[0];
      if (wrIf.wrValid && !rdy) mOvf = 1'b1;
      if (wrIf.wrValid && rdy) begin
        e.sel  = wrIf.wrSel;
        e.data = wrIf.wrData;
        e.be   = curBe;
        mq.push_back(e);
      end
      if (doC) begin
        for (int b = 0; b < 2; b++) begin
          if (h.be[b]) mReg[h.sel][b*8 +: 8] = h.data[b*8 +: 8];
        end
        void'(mq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (chkOn && rst_n) begin
      check("reg0", {16'h0, reg0}, {16'h0, mReg[0]});
      check("reg1", {16'h0, reg1}, {16'h0, mReg[1]});
      check("reg2", {16'h0, reg2}, {16'h0, mReg[2]});
      check("reg3", {16'h0, reg3}, {16'h0, mReg[3]});
      check("pending", {28'h0, pending}, {28'h0, expPending()});
      check("count", {30'h0, count}, 32'(mq.size()));
      check("wrReady", {31'h0, wrIf.wrReady}, {31'h0, (mq.size() < DEPTH)});
      check("overflowErr", {31'h0, overflowErr}, {31'h0, mOvf});
    end
  end

  task automatic step(input logic v, input logic [1:0] s, input logic [15:0] d,
                      input logic dr, input logic [1:0] be);
    wrIf.wrValid = v;
    wrIf.wrSel   = s;
    wrIf.wrData  = d;
    drainEn      = dr;
    curBe        = BE_ON ? be : 2'b11;
`ifdef DESTSEL_BYTE_EN
    wrIf.wrBe    = be;
`endif
    @(posedge clk);
    #2;
  endtask

  // Called 2 time units after a rising edge; reset is asserted and released between edges.
  task automatic resetPulse();
    rst_n = 1'b0;
    modelReset();
    #1;
    check("rst_count", {30'h0, count}, 32'h0);
    check("rst_pending", {28'h0, pending}, 32'h0);
    check("rst_regs", {reg0 | reg1, reg2 | reg3}, 32'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("post_rst_ready", {31'h0, wrIf.wrReady}, 32'h1);
  endtask

  initial begin
    wrIf.wrValid = 1'b0;
    wrIf.wrSel   = 2'd0;
    wrIf.wrData  = 16'h0;
    curBe        = 2'b11;
`ifdef DESTSEL_BYTE_EN
    wrIf.wrBe    = 2'b11;
`endif
    modelReset();
    #3;
    check("init_count", {30'h0, count}, 32'h0);
    check("init_pending", {28'h0, pending}, 32'h0);
    check("init_ovf", {31'h0, overflowErr}, 32'h0);
    check("init_regs", {reg0 | reg1, reg2 | reg3}, 32'h0);
    #9;
    rst_n = 1'b1;
    chkOn = 1'b1;
    @(posedge clk);
    #2;

    // Single write: pending for one cycle, value visible after the commit edge only.
    step(1'b1, 2'd2, 16'hBEEF, 1'b1, 2'b11);
    check("t1_reg2_early", {16'h0, reg2}, 32'h0);
    check("t1_pending", {28'h0, pending}, 32'h4);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    check("t1_reg2", {16'h0, reg2}, 32'hBEEF);
    check("t1_pending_clr", {28'h0, pending}, 32'h0);
    check("t1_others", {reg0 | reg1, reg3}, 32'h0);

    // Fill while stalled, overflow on the third offer, then drain in order.
    step(1'b1, 2'd0, 16'h1111, 1'b0, 2'b11);
    step(1'b1, 2'd1, 16'h2222, 1'b0, 2'b11);
    check("t2_ready", {31'h0, wrIf.wrReady}, 32'h0);
    check("t2_count", {30'h0, count}, 32'h2);
    check("t2_pending", {28'h0, pending}, 32'h3);
    step(1'b1, 2'd2, 16'h3333, 1'b0, 2'b11);
    check("t2_ovf", {31'h0, overflowErr}, 32'h1);
    check("t2_count_hold", {30'h0, count}, 32'h2);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    check("t2_reg0", {16'h0, reg0}, 32'h1111);
    check("t2_reg1_wait", {16'h0, reg1}, 32'h0);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    check("t2_reg1", {16'h0, reg1}, 32'h2222);
    check("t2_reg2_untouched", {16'h0, reg2}, 32'hBEEF);

    // Same-register ordering.
    step(1'b1, 2'd3, 16'hAAAA, 1'b0, 2'b11);
    step(1'b1, 2'd3, 16'h5555, 1'b0, 2'b11);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    check("t3_reg3_first", {16'h0, reg3}, 32'hAAAA);
    check("t3_pending_hold", {28'h0, pending}, 32'h8);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    check("t3_reg3_last", {16'h0, reg3}, 32'h5555);
    check("t3_pending_clr", {28'h0, pending}, 32'h0);

`ifdef DESTSEL_BYTE_EN
    step(1'b1, 2'd1, 16'h1234, 1'b1, 2'b11);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    check("be_full", {16'h0, reg1}, 32'h1234);
    step(1'b1, 2'd1, 16'hABCD, 1'b1, 2'b10);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    check("be_upper", {16'h0, reg1}, 32'hAB34);
    step(1'b1, 2'd1, 16'hFFFF, 1'b1, 2'b00);
    check("be_zero_count", {30'h0, count}, 32'h1);
    check("be_zero_pending", {28'h0, pending}, 32'h2);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    check("be_zero_reg1", {16'h0, reg1}, 32'hAB34);
    check("be_zero_empty", {30'h0, count}, 32'h0);
`endif

    // Steady stream: one accept and one commit per cycle.
    resetPulse();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 2'(k), 16'h0100 + 16'(k), 1'b1, 2'b11);
      check("t4_count", {30'h0, count}, 32'h1);
      if (k > 0) check("t4_commit", {16'h0, regAt((k - 1) % 4)}, 32'h0100 + 32'(k - 1));
    end
    check("t4_no_ovf", {31'h0, overflowErr}, 32'h0);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    check("t4_drained", {30'h0, count}, 32'h0);

    // Reset with queued writes: they must never appear.
    step(1'b1, 2'd0, 16'h7777, 1'b0, 2'b11);
    step(1'b1, 2'd1, 16'h8888, 1'b0, 2'b11);
    check("t5_count", {30'h0, count}, 32'h2);
    wrIf.wrValid = 1'b0;
    resetPulse();
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    step(1'b0, 2'd0, 16'h0, 1'b1, 2'b11);
    check("t5_discard", {reg0, reg1}, 32'h0);

    // Random traffic with phases of light and heavy draining.
    for (int i = 0; i < 2000; i++) begin
      logic dr;
      if ((i / 200) % 2 == 0) dr = ($urandom_range(0, 3) != 0);
      else                    dr = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 2) != 0), 2'($urandom), 16'($urandom), dr, 2'($urandom));
      if (i % 600 == 599) resetPulse();
    end

    chkOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
